// File: rtl/simple_fifo_reader_if.sv
// FIFO read port and downstream valid/ready stream used by simple_fifo_reader.
// master = the reader; slave = the FIFO plus stream consumer side.
interface simple_fifo_reader_if #(
    parameter int WIDTH = 32
);
    logic             fifo_re;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        output fifo_re,
        input  fifo_dout,
        input  fifo_empty,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_re,
        output fifo_dout,
        output fifo_empty,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/simple_fifo_reader.sv
// Burst drain engine: reads burst_len words from a registered-read FIFO and
// streams them out through a 2-entry buffer that hides the read latency.
module simple_fifo_reader #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    simple_fifo_reader_if.master bus
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | issuing reads / streaming words
    // FIN   | one-cycle done pulse; also accepts a new start
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining, pending;
    logic             infl;
    logic [1:0]       occ;
    logic [WIDTH-1:0] buf_head, buf_tail;
    logic             rd, acc, accept_cmd;
    logic [2:0]       level;

    always_comb begin
        state_nxt  = state;
        acc        = (occ != 2'd0) && bus.m_ready;
        // acc implies occ >= 1, so this never underflows
        level      = {1'b0, occ} + {2'b00, infl} - {2'b00, acc};
        rd         = (state == RUN) && (remaining != '0) && !bus.fifo_empty && (level < 3'd2);
        accept_cmd = start && (state != RUN);
        busy       = (state == RUN);
        done       = (state == FIN);
        case (state)
            IDLE, FIN: begin
                if (accept_cmd) begin
                    state_nxt = (burst_len == '0) ? FIN : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (acc && (pending == LEN_W'(1))) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fifo_re = rd;
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = buf_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            pending   <= '0;
            infl      <= 1'b0;
        end else begin
            state <= state_nxt;
            infl  <= rd;
            if (accept_cmd) begin
                remaining <= burst_len;
                pending   <= burst_len;
            end else begin
                if (rd) begin
                    remaining <= remaining - LEN_W'(1);
                end
                if (acc) begin
                    pending <= pending - LEN_W'(1);
                end
            end
        end
    end

    // Read data lands one cycle after fifo_re; infl marks that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ      <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            case ({infl, acc})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf_head <= bus.fifo_dout;
                    end else begin
                        buf_tail <= bus.fifo_dout;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_head <= bus.fifo_dout;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= bus.fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_fifo_reader.sv
// Self-checking bench for simple_fifo_reader: behavioural FIFO, stream
// scoreboard against the written word order, directed and random bursts.
module tb_simple_fifo_reader;
    localparam int WIDTH = 32;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             busy, done;

    simple_fifo_reader_if #(.WIDTH(WIDTH)) bus ();

    simple_fifo_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural FIFO with registered read data
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] written[$];
    int               pops = 0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] dout_r = '0;
    logic             empty_r = 1'b1;

    assign bus.fifo_dout  = dout_r;
    assign bus.fifo_empty = empty_r;

    always @(posedge clk) begin
        if (bus.fifo_re && q.size() > 0) begin
            dout_r <= q.pop_front();
            pops++;
        end
        if (wr_en) begin
            q.push_back(wr_data);
            written.push_back(wr_data);
        end
        empty_r <= (q.size() == 0);
    end

    logic ready_drv = 1'b1;
    logic rnd_ready = 1'b1;
    logic rand_mode = 1'b0;
    assign bus.m_ready = rand_mode ? rnd_ready : ready_drv;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Mid-cycle monitor: transaction-level model of one burst
    int               cyc = 0;
    int               burst_left = 0;
    int               reads_left = 0;
    int               out_ptr = 0;
    int               outstanding = 0;
    int               re_count = 0;
    int               hs_count = 0;
    int               start_cyc = 0;
    int               done_cyc = 0;
    int               hs_cyc[$];
    bit               done_due = 0;
    bit               stall_prev = 0;
    logic [WIDTH-1:0] data_prev = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            burst_left  = 0;
            reads_left  = 0;
            done_due    = 0;
            stall_prev  = 0;
            outstanding = 0;
            out_ptr     = pops;
        end else begin
            check("done", done, done_due);
            check("busy", busy, burst_left != 0);
            check("buffered_le_2", outstanding <= 2, 1'b1);
            if (stall_prev) begin
                check("stall_valid", bus.m_valid, 1'b1);
                check("stall_data", bus.m_data, data_prev);
            end
            if (done) begin
                check("reads_at_done", reads_left, 0);
                done_cyc = cyc;
            end
            if (bus.fifo_re) begin
                check("re_while_empty", bus.fifo_empty, 1'b0);
                check("re_over_budget", reads_left > 0, 1'b1);
                reads_left--;
                outstanding++;
                re_count++;
            end
            done_due = 0;
            if (bus.m_valid && bus.m_ready) begin
                check("hs_in_burst", burst_left > 0, 1'b1);
                check("data", bus.m_data,
                      (out_ptr < written.size()) ? {32'b0, written[out_ptr]} : 64'bx);
                out_ptr++;
                outstanding--;
                hs_count++;
                hs_cyc.push_back(cyc);
                if (burst_left == 1) done_due = 1;
                burst_left--;
            end
            if (start && !busy) begin
                start_cyc  = cyc;
                burst_left = int'(burst_len);
                reads_left = int'(burst_len);
                re_count   = 0;
                hs_count   = 0;
                hs_cyc.delete();
                if (burst_len == '0) done_due = 1;
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            data_prev  = bus.m_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [WIDTH-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        burst_len = LEN_W'(len);
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", done, 1'b1);
    endtask

    task automatic check_reset_values;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fifo_re", bus.fifo_re, 1'b0);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_data", bus.m_data, 0);
    endtask

    initial begin
        logic [7:0] pat;
        #1;
        check_reset_values();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic burst: exact latency and throughput
        foreach (written[i]) begin end
        write_word(32'h11);
        write_word(32'h22);
        write_word(32'h33);
        write_word(32'h44);
        tick();
        ready_drv = 1'b1;
        do_start(4);
        wait_done(50);
        check("basic_re_count", re_count, 4);
        tick();
        check("basic_hs_count", hs_cyc.size(), 4);
        for (int i = 0; i < 4 && i < hs_cyc.size(); i++)
            check("basic_hs_cycle", hs_cyc[i] - start_cyc, 3 + i);
        check("basic_done_cycle", done_cyc - start_cyc, 7);
        check("basic_fifo_empty", q.size(), 0);

        // Back-pressure pattern 1,0,0,1,0,1,1
        for (int i = 0; i < 4; i++) write_word(32'h100 + i);
        tick();
        pat = 8'b0110_1001;
        do_start(4);
        for (int i = 0; i < 7; i++) begin
            ready_drv = pat[i];
            tick();
        end
        ready_drv = 1'b1;
        wait_done(50);
        check("bp_re_count", re_count, 4);
        check("bp_hs_count", hs_count, 4);
        tick();

        // Empty stall: words trickle in 5 cycles apart
        do_start(3);
        write_word(32'hA);
        repeat (5) tick();
        write_word(32'hB);
        repeat (5) tick();
        write_word(32'hC);
        wait_done(60);
        check("empty_re_count", re_count, 3);
        check("empty_hs_count", hs_count, 3);
        tick();

        // Zero-length burst
        do_start(0);
        check("zero_done", done, 1'b1);
        check("zero_valid", bus.m_valid, 1'b0);
        tick();
        check("zero_done_once", done, 1'b0);

        // start while busy is ignored
        for (int i = 0; i < 4; i++) write_word(32'h200 + i);
        tick();
        do_start(2);
        start     = 1'b1;
        burst_len = LEN_W'(5);
        tick();
        start     = 1'b0;
        wait_done(50);
        check("ign_re_count", re_count, 2);
        check("ign_fifo_left", q.size(), 2);
        tick();

        // Reset mid-burst after 2nd word accepted
        for (int i = 0; i < 5; i++) write_word(32'h300 + i);
        tick();
        do_start(5);
        for (int n = 0; n < 50 && hs_count < 2; n++) tick();
        check("rstmid_reached", hs_count >= 2, 1'b1);
        reset = 1'b0;
        #1;
        check_reset_values();
        tick();
        tick();
        reset = 1'b1;
        tick();
        do_start(2);
        wait_done(50);
        check("rstmid_re_count", re_count, 2);
        tick();

        // Back-to-back bursts, second start in FIN
        for (int i = 0; i < 8; i++) write_word(32'h400 + i);
        tick();
        do_start(4);
        wait_done(50);
        check("b2b_first_re", re_count, 4);
        do_start(4);
        check("b2b_busy", busy, 1'b1);
        wait_done(50);
        check("b2b_second_re", re_count, 4);
        tick();

        // Random bursts with random back-pressure and FIFO fill pattern
        rand_mode = 1'b1;
        for (int b = 0; b < 12; b++) begin
            int len;
            len = $urandom_range(1, 12);
            fork
                begin
                    int w;
                    w = 0;
                    while (w < len) begin
                        wr_en   = ($urandom_range(0, 2) != 0);
                        wr_data = $urandom;
                        if (wr_en) w++;
                        tick();
                    end
                    wr_en = 1'b0;
                end
                begin
                    do_start(len);
                    wait_done(400);
                    check("rand_re_count", re_count, len);
                    check("rand_hs_count", hs_count, len);
                end
            join
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_mode = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simple_fifo_reader.md
# simple_fifo_reader

Read-side drain engine for `simple_fifo` and `simple_fifo_32`. On a `start` command it pulls exactly `burst_len` words out of the FIFO read port and presents them on a valid/ready stream. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so it sustains one word per cycle under no back-pressure. It sits between a FIFO instance and any downstream stream consumer, and is the consumer-side counterpart to the FIFO's `we`/`din` writer.

## Interface

Parameters:
- `WIDTH`, 32, data width; must match the attached FIFO.
- `LEN_W`, 16, width of the burst length and internal counters.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `reset`  in  1  — asynchronous, active-low; asserted at 0.
- `start`  in  1  — burst request; sampled only while `busy`=0.
- `burst_len`  in  LEN_W  — number of words to drain; latched when `start` is accepted.
- `busy`  out  1  — a burst is in progress.
- `done`  out  1  — one-cycle pulse after the last word is accepted downstream.
- `fifo_re`  out  1  — FIFO read enable.
- `fifo_dout`  in  WIDTH  — FIFO read data; valid the cycle after `fifo_re`.
- `fifo_empty`  in  1  — FIFO empty flag.
- `m_valid`  out  1  — output word valid.
- `m_data`  out  WIDTH  — output word.
- `m_ready`  in  1  — downstream accepts the word when `m_valid` and `m_ready` are both 1.

## Operation

- State machine: IDLE, RUN, FIN.
- IDLE:
  - `busy`=0.
  - `start`=1 latches `burst_len` into `remaining` (words not yet requested) and `pending` (words not yet accepted).
  - If `burst_len`=0, go to FIN. Otherwise go to RUN.
- RUN:
  - `busy`=1.
  - Let occ = buffer occupancy (0..2), infl = 1 if `fifo_re` was asserted last cycle, and acc = `m_valid` & `m_ready`.
  - `fifo_re` = (`remaining`≠0) & !`fifo_empty` & (occ + infl − acc < 2). This is combinational from `m_ready` and `fifo_empty`.
  - Each `fifo_re` decrements `remaining`.
  - The cycle after `fifo_re`, `fifo_dout` is written into the buffer tail.
  - Each acc decrements `pending`.
  - When acc occurs with `pending`=1, go to FIN.
- FIN:
  - `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE.
  - `start` is accepted in FIN (it acts as IDLE for command acceptance).
- Buffer:
  - 2-entry FIFO with order preserved.
  - `m_valid` = (occ≠0). `m_data` = head entry.
  - A simultaneous write and accept is legal and leaves occ unchanged.
- `start` while `busy`=1 is ignored; it has no effect on counters.
- `fifo_re` is never 1 when `fifo_empty`=1, and never 1 when `remaining`=0. The block never reads more than `burst_len` words.
- Counters are LEN_W bits. `burst_len` = 2^LEN_W−1 is legal; there is no wrap.

## Timing

- Reset values: `busy`=0, `done`=0, `fifo_re`=0, `m_valid`=0, `m_data`=0. State is IDLE, counters are 0 and the buffer is empty.
- Reset mid-burst aborts immediately; partially read words are discarded. The FIFO itself is not reset by this block.
- Latency with the FIFO non-empty and `start` sampled at edge 0:
  - `fifo_re`=1 in cycle 1.
  - Data is captured at edge 2.
  - `m_valid`=1 in cycle 3.
- Throughput: with `m_ready` held at 1 and the FIFO never empty, one word per cycle and no bubbles after the first.
- Back-pressure: while `m_valid`=1 and `m_ready`=0, `m_data` holds stable. At most 2 words are buffered, and `fifo_re` stops once occ + infl reaches 2.
- FIFO empty mid-burst: `fifo_re` pauses and resumes in the first cycle `fifo_empty`=0. `m_valid` drops once the buffer drains.
- `done` is asserted in the cycle after the final handshake, and `busy` falls in that same cycle.
- Zero-length burst: `done` is asserted in the cycle after `start`. `fifo_re` and `m_valid` never assert.

## Test plan

- Basic burst:
  - Stimulus: FIFO preloaded with 0x11, 0x22, 0x33, 0x44; `burst_len`=4; `m_ready`=1.
  - Required response: words in order on cycles 3–6; `done` on cycle 7; FIFO ends empty; exactly 4 `fifo_re` pulses.
- Back-pressure:
  - Stimulus: same preload; `m_ready` toggled 1,0,0,1,0,1,1.
  - Required response: no word lost or duplicated; `m_data` stable while stalled; occ never exceeds 2.
- Empty stall:
  - Stimulus: `burst_len`=3, FIFO initially empty; write 0xA, then 0xB, then 0xC 5 cycles apart.
  - Required response: `fifo_re` never asserted while `fifo_empty`=1; all three words delivered; `done` after 0xC is accepted.
- Zero length and ignored start:
  - Stimulus: `burst_len`=0, then a `start` pulse while a 2-word burst is busy.
  - Required response: `done` one cycle after the first `start`; the second `start` has no effect and exactly 2 words are read.
- Reset mid-burst:
  - Stimulus: `reset`=0 after the 2nd of 5 words is accepted.
  - Required response: all outputs return to reset values asynchronously; `done` never pulses; after release, a new `burst_len`=2 burst reads the next FIFO words correctly.
- Back-to-back bursts:
  - Stimulus: 8 words preloaded; `start` with `burst_len`=4 in the FIN cycle of the previous 4-word burst.
  - Required response: the second burst is accepted and all 8 words are delivered in order.
